// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit: fetch FSM states,
// the prefetch FIFO entry layout and the PC stride.
package ifu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO of fetch entries with single-cycle flush and
// occupancy count. DEPTH must be a power of two so the pointers wrap naturally.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_n && !flush) assert (!(push && full && !do_pop));
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sequencing, imem request/response tracking, prefetch
// buffering and redirect flush. IFU_MISALIGN_TRAP_EN enables the misaligned-target trap.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // All channels: a transfer happens in a cycle where valid && ready; the source holds
  // its payload stable while valid && !ready. The imem response channel has no ready.
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic        fetch_misalign,
`endif
  output state_t      dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_q;
  logic [31:0]   tgt_pc;
  logic [CW-1:0] outst, outst_eff, drop_cnt, fifo_cnt;
  logic          misalign;
  logic          req_fire;
  logic          push;
  logic          fifo_empty;
  fetch_entry_t  wdata, head;

`ifdef IFU_MISALIGN_TRAP_EN
  assign tgt_pc = redirect_pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              misalign <= 1'b0;
    else if (redirect_valid) misalign <= (redirect_pc[1:0] != 2'b00);
  end
  assign fetch_misalign = misalign;
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign tgt_pc   = {redirect_pc[31:2], 2'b00};
  assign misalign = 1'b0;
`endif

  // Requests still owed a response once this cycle's response is retired.
  assign outst_eff = outst - CW'(imem_resp_valid);
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign push      = imem_resp_valid && !redirect_valid && (drop_cnt == '0);
  assign wdata     = '{instr: imem_resp_data, pc: pc_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = RUN;
      RUN:   if (redirect_valid && outst_eff != '0) state_nxt = FLUSH;
      FLUSH: begin
        if (redirect_valid)
          state_nxt = FLUSH;
        else if (drop_cnt == '0 || (drop_cnt == CW'(1) && imem_resp_valid))
          state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    if (state != IDLE && !redirect_valid && !misalign &&
        outst < CW'(MAX_OUTST) && (SW'(outst) + SW'(fifo_cnt)) < SW'(FIFO_DEPTH))
      imem_req_valid = 1'b1;
    imem_req_addr = fetch_pc;
    instr_valid   = !fifo_empty;
    instr         = fifo_empty ? NOP_INSTR : head.instr;
    instr_pc      = fifo_empty ? 32'h0 : head.pc;
    dbg_state     = state;
  end

  // pc_q tracks the PC of the oldest request whose response will be kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      pc_q     <= RESET_PC;
      outst    <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= tgt_pc;
      pc_q     <= tgt_pc;
      outst    <= outst_eff;
      drop_cnt <= outst_eff;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      outst <= outst + CW'(req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        else                pc_q     <= pc_q + PC_STEP;
      end
    end
  end

  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .pop   (instr_ready),
    .wdata (wdata),
    .rdata (head),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order memory model with random latency,
// scoreboard of requested PCs since the last redirect, directed cases plus random traffic.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  localparam int FIFO_DEPTH = 2;
  localparam int MAX_OUTST  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif
  state_t      dbg_state;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
`ifdef IFU_MISALIGN_TRAP_EN
    .fetch_misalign  (fetch_misalign),
`endif
    .dbg_state       (dbg_state)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  int          checks = 0, errors = 0, cyc = 0;
  int          lat_min = 1, lat_max = 1, ready_pct = 100, take_pct = 100, last_due = 0;
  int          req_cnt = 0, del_cnt = 0, first_req_cyc = -1, first_val_cyc = -1;
  logic [31:0] req_exp = 32'h0, last_del_pc = 32'h0, prev_req_addr = 32'h0;
  logic [31:0] wrap_next = 32'h0, redir_first_addr = 32'h0;
  logic        wrap_seen = 1'b0, redir_first_seen = 1'b0, last_req_valid = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, observe, update models.
  task automatic step(input logic redir, input logic [31:0] rpc);
    logic resp_now, req_hs, ins_hs;
    int   due;
    resp_now        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? word_at(mem_q[0].addr) : $urandom;
    imem_req_ready  = ($urandom_range(99) < ready_pct);
    instr_ready     = ($urandom_range(99) < take_pct);
    redirect_valid  = redir;
    redirect_pc     = rpc;
    #1;
    req_hs         = imem_req_valid && imem_req_ready;
    ins_hs         = instr_valid && instr_ready;
    last_req_valid = imem_req_valid;
    if (redir) chk("req_during_redirect", 32'(imem_req_valid), 32'h0);
    if (instr_valid && first_val_cyc < 0) first_val_cyc = cyc;
    if (ins_hs) begin
      if (exp_q.size() == 0) chk("spurious_instr", 32'(instr_valid), 32'h0);
      else begin
        chk("instr_pc", instr_pc, exp_q[0]);
        chk("instr_word", instr, word_at(exp_q[0]));
        void'(exp_q.pop_front());
      end
      last_del_pc = instr_pc;
      del_cnt++;
    end
    if (resp_now) void'(mem_q.pop_front());
    if (redir) begin
      exp_q.delete();
      req_exp          = {rpc[31:2], 2'b00};
      redir_first_seen = 1'b0;
    end
    if (req_hs) begin
      chk("req_addr", imem_req_addr, req_exp);
      exp_q.push_back(req_exp);
      req_exp = req_exp + 32'd4;
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: imem_req_addr, due: due});
      chk("outstanding_limit", 32'(mem_q.size() <= MAX_OUTST), 32'h1);
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (prev_req_addr == 32'hFFFF_FFFC) begin
        wrap_seen = 1'b1;
        wrap_next = imem_req_addr;
      end
      if (!redir_first_seen) begin
        redir_first_seen = 1'b1;
        redir_first_addr = imem_req_addr;
      end
      prev_req_addr = imem_req_addr;
      req_cnt++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    instr_ready     = 1'b0;
    mem_q.delete();
    exp_q.delete();
    req_exp       = 32'h0;
    first_req_cyc = -1;
    first_val_cyc = -1;
    repeat (3) begin
      @(negedge clk);
      cyc++;
    end
    last_due = cyc;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef IFU_MISALIGN_TRAP_EN
    chk("rst_misalign", 32'(fetch_misalign), 32'h0);
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    int rel_cyc, d0, r0, n;
    int exp_eff;
    do_reset();
    rel_cyc = cyc;

    // Zero-wait memory, decode always ready.
    repeat (12) step(1'b0, 32'h0);
    chk("first_req_cycle", 32'(first_req_cyc - rel_cyc), 32'd1);
    chk("first_word_latency", 32'(first_val_cyc - first_req_cyc), 32'd2);
    chk("t1_deliveries", 32'(del_cnt >= 4), 32'h1);

    // Decode stalls: buffer fills to depth, requests stop, then drains in order.
    take_pct = 0;
    step(1'b1, 32'h40);
    repeat (12) step(1'b0, 32'h0);
    chk("t2_req_stalled", 32'(last_req_valid), 32'h0);
    chk("t2_buffered", 32'(exp_q.size()), 32'(FIFO_DEPTH));
    chk("t2_outstanding", 32'(mem_q.size()), 32'h0);
    chk("t2_instr_valid", 32'(instr_valid), 32'h1);
    take_pct = 100;
    d0 = del_cnt;
    repeat (10) step(1'b0, 32'h0);
    chk("t2_drained", 32'(del_cnt - d0 >= FIFO_DEPTH), 32'h1);

    // Redirect with two requests in flight.
    lat_min = 3; lat_max = 3;
    n = 0;
    while (mem_q.size() != 2 && n < 50) begin step(1'b0, 32'h0); n++; end
    chk("t3_two_outstanding", 32'(mem_q.size()), 32'd2);
    exp_eff = mem_q.size() - ((mem_q.size() > 0 && mem_q[0].due <= cyc) ? 1 : 0);
    step(1'b1, 32'h100);
    chk("t3_state_flush", 32'(dbg_state), (exp_eff > 0) ? 32'(FLUSH) : 32'(RUN));
    d0 = del_cnt; n = 0;
    while (del_cnt == d0 && n < 50) begin step(1'b0, 32'h0); n++; end
    chk("t3_first_pc", last_del_pc, 32'h100);

    // Redirect coinciding with a response and a ready memory.
    lat_min = 2; lat_max = 2;
    n = 0;
    while (!(mem_q.size() == 2 && mem_q[0].due <= cyc && mem_q[1].due == cyc + 1) && n < 60) begin
      step(1'b0, 32'h0);
      n++;
    end
    chk("t4_setup", 32'(mem_q.size()), 32'd2);
    step(1'b1, 32'h200);
    chk("t4_state_flush", 32'(dbg_state), 32'(FLUSH));
    step(1'b0, 32'h0);
    chk("t4_state_run", 32'(dbg_state), 32'(RUN));
    d0 = del_cnt; n = 0;
    while (del_cnt == d0 && n < 50) begin step(1'b0, 32'h0); n++; end
    chk("t4_first_pc", last_del_pc, 32'h200);

    // Fetch PC wraps around the top of the address space.
    lat_min = 1; lat_max = 1;
    wrap_seen = 1'b0;
    step(1'b1, 32'hFFFF_FFF8);
    repeat (20) step(1'b0, 32'h0);
    chk("t5_wrap_seen", 32'(wrap_seen), 32'h1);
    chk("t5_wrap_addr", wrap_next, 32'h0);

    // Misaligned redirect target.
`ifdef IFU_MISALIGN_TRAP_EN
    r0 = req_cnt;
    step(1'b1, 32'h102);
    repeat (10) step(1'b0, 32'h0);
    chk("t6_misalign_flag", 32'(fetch_misalign), 32'h1);
    chk("t6_no_requests", 32'(req_cnt - r0), 32'h0);
    chk("t6_fifo_empty", 32'(instr_valid), 32'h0);
    step(1'b1, 32'h180);
    chk("t6_misalign_clear", 32'(fetch_misalign), 32'h0);
`else
    r0 = 0;
    step(1'b1, 32'h102);
    n = 0;
    while (!redir_first_seen && n < 20) begin step(1'b0, 32'h0); n++; end
    chk("t6_first_req_seen", 32'(redir_first_seen), 32'h1);
    chk("t6_aligned_addr", redir_first_addr, 32'h100);
`endif

    // Random traffic with occasional redirects.
    lat_min = 1; lat_max = 4; ready_pct = 70; take_pct = 60;
    for (int i = 0; i < 1500; i++)
      step($urandom_range(99) < 3, $urandom & 32'hFFFF_FFFC);

    // Reset in the middle of traffic, then more random traffic.
    do_reset();
    for (int i = 0; i < 300; i++)
      step($urandom_range(99) < 3, $urandom & 32'hFFFF_FFFC);

    // Stop issuing and drain: every requested word must come out.
    ready_pct = 0; take_pct = 100;
    n = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 100) begin
      step(1'b0, 32'h0);
      n++;
    end
    chk("drain_exp_empty", 32'(exp_q.size()), 32'h0);
    chk("drain_instr_valid", 32'(instr_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
